// File: rtl/nor_gate_sweep_checker.sv
// Sweep stimulus/response checker for a two-input gate cell.
// Drives all four {a,b} vectors, settles, samples y and scores it.
module nor_gate_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  TRUTH         = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [1:0] idx_q;
  logic [3:0] cnt_q;
  logic       a_q;
  logic       b_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] mask_q;
  logic [2:0] err_q;

  logic       mism_d;
  logic [3:0] mask_d;
  logic [2:0] err_d;

  // Score the current vector; x/z never match a 0/1 truth bit.
  always_comb begin
    mism_d = 1'b0;
    mask_d = mask_q;
    err_d  = err_q;
    if (y_in !== TRUTH[idx_q]) begin
      mism_d = 1'b1;
    end
    if (mism_d) begin
      mask_d = mask_q | (4'b0001 << idx_q);
      err_d  = err_q + 3'd1;
    end
  end

  // Sweep sequencer with registered drives and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mask_q  <= 4'd0;
      err_q   <= 3'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            mask_q  <= 4'd0;
            err_q   <= 3'd0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            state_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          mask_q <= mask_d;
          err_q  <= err_d;
          if (idx_q == 2'd3) begin
            done_q  <= 1'b1;
            pass_q  <= (mask_d == 4'd0);
            state_q <= S_DONE;
          end else begin
            idx_q        <= idx_q + 2'd1;
            {a_q, b_q}   <= idx_q + 2'd1;
            cnt_q        <= 4'd0;
            state_q      <= S_SETTLE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;
  assign err_count = err_q;

endmodule

// File: doc/nor_gate_sweep_checker.md
# nor_gate_sweep_checker

Self-checking stimulus/response stage for a two-input gate under test. It drives the gate's `a`/`b` inputs through all four input combinations, waits a programmable settle time, samples the gate output `y` and compares it against an expected truth table. It reports per-vector mismatches and an overall pass flag. The block sits directly upstream of the structural CMOS NOR cell, feeding its inputs, and directly downstream of it, consuming its output. Its purpose is regression of transistor-level gate cells inside a clocked bench.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles the gate output is allowed to settle before sampling. Legal range 1..15.
- `TRUTH`, default 4'b0001: expected `y` per vector, indexed by `{a,b}`. Bit 0 is ab=00 and bit 3 is ab=11. The default is NOR.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a sweep; sampled only in IDLE.
- `a_out`, output, 1: registered drive to gate input `a`.
- `b_out`, output, 1: registered drive to gate input `b`.
- `y_in`, input, 1: gate output under test; may be 0, 1, x or z.
- `busy`, output, 1: high from sweep acceptance through the DONE cycle.
- `done`, output, 1: one-cycle pulse at sweep completion.
- `pass`, output, 1: high after a sweep with zero mismatches; held until the next accepted start.
- `fail_mask`, output, 4: bit i set if vector i (`{a,b}`=i) mismatched.
- `err_count`, output, 3: popcount of `fail_mask`, range 0..4.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE. A 2-bit vector index `idx` and a 4-bit settle counter `cnt` are used.
- IDLE with `start`=1 at an edge (the accept edge) sets:
  - `idx`=0, `{a_out,b_out}`=00, `cnt`=0;
  - `fail_mask`=0, `err_count`=0, `pass`=0;
  - next state SETTLE.
- SETTLE: `cnt` increments each edge. When `cnt`==SETTLE_CYCLES-1, the next state is SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle): at its closing edge, `y_in` is compared with `TRUTH[idx]` using case equality.
  - x or z on `y_in` always counts as a mismatch.
  - On mismatch, `fail_mask[idx]` is set and `err_count` increments.
  - If `idx`<3: `idx`++, `{a_out,b_out}`=`idx`+1, `cnt`=0, next state SETTLE.
  - If `idx`==3: next state DONE.
- DONE (one cycle): `done`=1 and `pass`=1 iff the final `fail_mask`==0. Next state IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE. No queuing.
- In IDLE, `a_out`/`b_out` hold the last applied vector (11 after a completed sweep).
- `pass`, `fail_mask` and `err_count` hold their values through IDLE until the next accepted start.

## Timing
- Reset values: state IDLE, `a_out`=0, `b_out`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `err_count`=0, `idx`=0, `cnt`=0.
- `rst` has priority over `start` and over every state. Asserting `rst` mid-sweep aborts the sweep: no `done` pulse, results cleared.
- All outputs are registered.
  - `busy` rises at the accept edge and falls at the edge ending DONE.
  - `done` is high only during the DONE cycle.
- Each vector occupies SETTLE_CYCLES+1 cycles. `y_in` is sampled SETTLE_CYCLES+1 edges after `a_out`/`b_out` change.
- `done` asserts 4·(SETTLE_CYCLES+1) cycles after the accept edge: 12 cycles for the default.
- Back-to-back operation: the earliest next accept is the edge ending the first IDLE cycle after DONE.

## Test plan
- Default parameters, connected to a correct CMOS NOR cell, `start` pulsed once. Required response:
  - `a_out`/`b_out` step 00, 01, 10, 11, each held 3 cycles;
  - `done` one cycle, 12 cycles after the accept edge;
  - `pass`=1, `fail_mask`=0000, `err_count`=0.
- `y_in` tied to 0 -> `fail_mask`=0001, `err_count`=1, `pass`=0.
- `y_in` tied to 1 -> `fail_mask`=1110, `err_count`=3, `pass`=0.
- `y_in` left undriven (z), then repeated with `y_in`=x -> `fail_mask`=1111, `err_count`=4, `pass`=0 in both cases.
- `start` held high for an entire sweep -> exactly one sweep per IDLE acceptance.
  - Second sweep accepted only after DONE plus one IDLE cycle.
  - Results of the first sweep are visible in that IDLE cycle.
- `rst` asserted for one cycle during the vector-2 SETTLE phase -> next cycle shows:
  - all outputs at reset values;
  - no `done` pulse;
  - a new `start` runs a full clean sweep with `pass`=1.
